// File: rtl/huffman_packer_pkg.sv
// Shared types and constants for the Huffman bitstream packer.
// Holds the FSM encoding and the gray-symbol to table-index mapping.
package huffman_packer_pkg;

   localparam int NSYM = 6;
   localparam logic [2:0] SYM_DEFAULT_IDX = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Symbols 1..5 index their own table entry; every other value shares entry 6.
   function automatic logic [2:0] sym_to_idx(input logic [7:0] sym);
      if (sym >= 8'd1 && sym <= 8'd5) return sym[2:0];
      return SYM_DEFAULT_IDX;
   endfunction

endpackage

// File: rtl/huffman_len_lut.sv
// Code length lookup: popcount of a contiguous-ones mask (0..8).
module huffman_len_lut (
   input  logic [7:0] mask,
   output logic [3:0] len
);

   always_comb begin
      len = 4'd0;
      for (int i = 0; i < 8; i++) begin
         len = len + {3'b000, mask[i]};
      end
   end

endmodule

// File: rtl/huffman_packer.sv
// Packs Huffman codes for a stream of gray symbols into MSB-first bytes.
// Byte out: out_valid/out_ready; symbol in: sym_valid/sym_ready; a transfer happens when both are high at a rising edge.
module huffman_packer
   import huffman_packer_pkg::*;
#(
   parameter int BUF_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        code_valid,
   input  logic [7:0]  HC1,
   input  logic [7:0]  HC2,
   input  logic [7:0]  HC3,
   input  logic [7:0]  HC4,
   input  logic [7:0]  HC5,
   input  logic [7:0]  HC6,
   input  logic [7:0]  M1,
   input  logic [7:0]  M2,
   input  logic [7:0]  M3,
   input  logic [7:0]  M4,
   input  logic [7:0]  M5,
   input  logic [7:0]  M6,
   input  logic        sym_valid,
   input  logic [7:0]  sym_data,
   input  logic        sym_last,
   output logic        sym_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic [15:0] bit_total,
   output logic        done,
   output logic [1:0]  state_dbg
);

   state_e            state_q, state_d;
   logic [7:0]        hc_q [1:NSYM];
   logic [7:0]        hc_d [1:NSYM];
   logic [7:0]        m_q  [1:NSYM];
   logic [7:0]        m_d  [1:NSYM];
   logic [BUF_W-1:0]  buf_q, buf_d, buf_pop;
   logic [4:0]        cnt_q, cnt_d, cnt_pop;
   logic [15:0]       bit_total_q, bit_total_d;

   logic [2:0]        idx;
   logic [7:0]        mask_sel;
   logic [7:0]        code_m;
   logic [3:0]        len;
   logic [5:0]        sh;
   logic [31:0]       code_ext;
   logic              sym_fire, byte_fire;

   assign idx      = sym_to_idx(sym_data);
   assign mask_sel = m_q[idx];
   // Contiguous masks make AND-ing equivalent to taking the low len bits.
   assign code_m   = hc_q[idx] & mask_sel;

   huffman_len_lut u_len_lut (
      .mask (mask_sel),
      .len  (len)
   );

   assign sym_ready = (state_q == ST_RUN) && (cnt_q < 5'd8);
   assign out_valid = (cnt_q >= 5'd8) || ((state_q == ST_FLUSH) && (cnt_q != 5'd0));
   assign out_last  = out_valid && (state_q == ST_FLUSH) && (cnt_q <= 5'd8);
   assign out_data  = buf_q[BUF_W-1 -: 8];
   assign done      = (state_q == ST_DONE);
   assign bit_total = bit_total_q;
   assign state_dbg = state_q;

   assign sym_fire  = sym_valid && sym_ready;
   assign byte_fire = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      hc_d        = hc_q;
      m_d         = m_q;
      bit_total_d = bit_total_q;
      buf_pop     = byte_fire ? (buf_q << 8) : buf_q;
      cnt_pop     = byte_fire ? ((cnt_q >= 5'd8) ? (cnt_q - 5'd8) : 5'd0) : cnt_q;
      buf_d       = buf_pop;
      cnt_d       = cnt_pop;
      sh          = 6'(BUF_W) - {1'b0, cnt_pop} - {2'b00, len};
      code_ext    = {24'd0, code_m} << sh;

      // The pop is applied before the push so a same-cycle push lands behind the remaining bits.
      if (sym_fire) begin
         buf_d       = buf_pop | code_ext[BUF_W-1:0];
         cnt_d       = cnt_pop + {1'b0, len};
         bit_total_d = bit_total_q + {12'd0, len};
      end

      case (state_q)
         ST_IDLE: begin
            if (code_valid) begin
               hc_d[1] = HC1; hc_d[2] = HC2; hc_d[3] = HC3;
               hc_d[4] = HC4; hc_d[5] = HC5; hc_d[6] = HC6;
               m_d[1]  = M1;  m_d[2]  = M2;  m_d[3]  = M3;
               m_d[4]  = M4;  m_d[5]  = M5;  m_d[6]  = M6;
               bit_total_d = 16'd0;
               state_d     = ST_RUN;
            end
         end
         ST_RUN: begin
            if (sym_fire && sym_last) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (cnt_d == 5'd0) state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         bit_total_q <= '0;
         for (int i = 1; i <= NSYM; i++) begin
            hc_q[i] <= '0;
            m_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         bit_total_q <= bit_total_d;
         for (int i = 1; i <= NSYM; i++) begin
            hc_q[i] <= hc_d[i];
            m_q[i]  <= m_d[i];
         end
      end
   end

endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: hand-computed byte streams checked through a scoreboard.
module tb_huffman_packer;

   logic        clk;
   logic        reset;
   logic        code_valid;
   logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
   logic [7:0]  M1, M2, M3, M4, M5, M6;
   logic        sym_valid;
   logic [7:0]  sym_data;
   logic        sym_last;
   logic        sym_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready;
   logic [15:0] bit_total;
   logic        done;
   logic [1:0]  state_dbg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];

   huffman_packer dut (
      .clk        (clk),
      .reset      (reset),
      .code_valid (code_valid),
      .HC1 (HC1), .HC2 (HC2), .HC3 (HC3), .HC4 (HC4), .HC5 (HC5), .HC6 (HC6),
      .M1  (M1),  .M2  (M2),  .M3  (M3),  .M4  (M4),  .M5  (M5),  .M6  (M6),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .sym_last   (sym_last),
      .sym_ready  (sym_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .bit_total  (bit_total),
      .done       (done),
      .state_dbg  (state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte monitor: inputs only change just after a rising edge, so the handshake seen here is the one taken next edge.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) got_q.push_back({out_last, out_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic load_tables(input logic [7:0] m3);
      HC1 = 8'h01; HC2 = 8'h01; HC3 = 8'h00; HC4 = 8'h02; HC5 = 8'h06; HC6 = 8'h07;
      M1  = 8'h01; M2  = 8'h03; M3  = m3;    M4  = 8'h0F; M5  = 8'h1F; M6  = 8'h1F;
      code_valid = 1'b1;
      @(posedge clk); #1;
      code_valid = 1'b0;
      check("load_state", 32'(state_dbg), 32'(S_RUN));
   endtask

   task automatic send_sym(input logic [7:0] s, input logic last);
      int n = 0;
      sym_valid = 1'b1;
      sym_data  = s;
      sym_last  = last;
      while (!sym_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 200) check("sym_ready_timeout", 32'(sym_ready), 32'd1);
      @(posedge clk); #1;
      sym_valid = 1'b0;
      sym_last  = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("done_pulse", 32'(done), 32'd1);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("back_to_idle", 32'(state_dbg), 32'(S_IDLE));
      @(posedge clk); #1;
   endtask

   task automatic compare_bytes(input string tag);
      logic [8:0] g, e;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_byte"}, 32'(g), 32'(e));
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      reset = 1'b0; code_valid = 1'b0;
      HC1 = '0; HC2 = '0; HC3 = '0; HC4 = '0; HC5 = '0; HC6 = '0;
      M1 = '0; M2 = '0; M3 = '0; M4 = '0; M5 = '0; M6 = '0;
      sym_valid = 1'b0; sym_data = '0; sym_last = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_sym_ready", 32'(sym_ready), 32'd0);
      check("rst_bit_total", 32'(bit_total), 32'd0);
      check("rst_state",     32'(state_dbg), 32'(S_IDLE));
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: 1 01 000 0010 -> 10100000 10(000000)
      load_tables(8'h07);
      exp_q.push_back({1'b0, 8'hA0});
      exp_q.push_back({1'b1, 8'h80});
      send_sym(8'd1, 1'b0); send_sym(8'd2, 1'b0); send_sym(8'd3, 1'b0); send_sym(8'd4, 1'b1);
      wait_done();
      compare_bytes("t1");
      check("t1_bit_total", 32'(bit_total), 32'd10);

      // 2: eight '1' bits fill exactly one byte, no pad byte
      load_tables(8'h07);
      exp_q.push_back({1'b1, 8'hFF});
      for (int i = 0; i < 8; i++) send_sym(8'd1, (i == 7));
      wait_done();
      compare_bytes("t2");
      check("t2_bit_total", 32'(bit_total), 32'd8);

      // 3: 00110 00111 00110 00111 -> 00110001 11001100 0111(0000), with backpressure
      load_tables(8'h07);
      exp_q.push_back({1'b0, 8'h31});
      exp_q.push_back({1'b0, 8'hCC});
      exp_q.push_back({1'b1, 8'h70});
      out_ready = 1'b0;
      send_sym(8'd5, 1'b0); send_sym(8'd6, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_sym_ready", 32'(sym_ready), 32'd0);
         check("t3_hold_out_valid", 32'(out_valid), 32'd1);
         check("t3_hold_out_data",  32'(out_data),  32'h31);
         check("t3_hold_out_last",  32'(out_last),  32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_sym(8'd5, 1'b0); send_sym(8'd6, 1'b1);
      wait_done();
      compare_bytes("t3");
      check("t3_bit_total", 32'(bit_total), 32'd20);

      // 4: out-of-range symbols 0 and 9 both code as sym6 '00111'
      load_tables(8'h07);
      exp_q.push_back({1'b0, 8'h39});
      exp_q.push_back({1'b1, 8'hC0});
      send_sym(8'd0, 1'b0); send_sym(8'd9, 1'b1);
      wait_done();
      compare_bytes("t4");
      check("t4_bit_total", 32'(bit_total), 32'd10);

      // 5: zero-length sym3 adds nothing; only sym1's '1' remains
      load_tables(8'h00);
      exp_q.push_back({1'b1, 8'h80});
      send_sym(8'd3, 1'b0); send_sym(8'd3, 1'b0); send_sym(8'd1, 1'b1);
      wait_done();
      compare_bytes("t5");
      check("t5_bit_total", 32'(bit_total), 32'd1);

      // 6: reset mid-stream with 5 bits buffered
      load_tables(8'h07);
      send_sym(8'd5, 1'b0);
      check("t6_bits_before", 32'(bit_total), 32'd5);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_state",     32'(state_dbg), 32'(S_IDLE));
      check("t6_rst_bit_total", 32'(bit_total), 32'd0);
      #3 reset = 1'b1;
      sym_valid = 1'b1; sym_data = 8'd1; code_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_reload_ready", 32'(sym_ready), 32'd0);
      end
      sym_valid = 1'b0;
      check("t6_no_bytes", 32'(got_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
